// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared state type and sizing/saturation helpers for the bit-serial MVM
package mvm_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} mvm_state_t;

  function automatic int acc_bits(input int in_w, input int wt_w, input int size);
    return in_w + wt_w + $clog2(size) + 1;
  endfunction

  // Clips a sign-extended accumulator to out_bits signed range.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] acc,
                                                  input int out_bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (out_bits >= 64) return acc;
    hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/mvm_bitslice_dot.sv
// rtl/mvm_bitslice_dot.sv - one crossbar column: sum of weights whose input bit is set
module mvm_bitslice_dot #(
  parameter int XBAR_SIZE = 16,
  parameter int WT_BITS   = 16,
  parameter int P_BITS    = WT_BITS + $clog2(XBAR_SIZE) + 1
) (
  input  logic [XBAR_SIZE-1:0]              in_bits,
  input  logic [XBAR_SIZE-1:0][WT_BITS-1:0] col_wt,
  output logic signed [P_BITS-1:0]          p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < XBAR_SIZE; i++) begin
      if (in_bits[i]) p = p + P_BITS'($signed(col_wt[i]));
    end
  end

endmodule

// File: rtl/mvm_bitserial.sv
// rtl/mvm_bitserial.sv - bit-serial matrix-vector multiply over a programmable weight crossbar
module mvm_bitserial
  import mvm_pkg::*;
#(
  parameter int XBAR_SIZE = 16,
  parameter int IN_BITS   = 16,
  parameter int WT_BITS   = 16,
  parameter int OUT_BITS  = 32,
  parameter int N_BITS    = $clog2(IN_BITS + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  reset_wt,
  input  logic                                  mvm_start,
  input  logic [N_BITS-1:0]                     n,
  input  logic                                  in_signed,
  input  logic [XBAR_SIZE-1:0][IN_BITS-1:0]     xbar_input,
  input  logic                                  prog_wt,
  input  logic [$clog2(XBAR_SIZE)-1:0]          wt_row_addr,
  input  logic [XBAR_SIZE-1:0][WT_BITS-1:0]     wr_weight,
  output logic                                  busy,
  output logic                                  mvm_done,
  output logic                                  sat,
  output logic [XBAR_SIZE-1:0][OUT_BITS-1:0]    xbar_output
);

  localparam int ACC_BITS = acc_bits(IN_BITS, WT_BITS, XBAR_SIZE);
  localparam int P_BITS   = WT_BITS + $clog2(XBAR_SIZE) + 1;
  localparam int K_BITS   = $clog2(IN_BITS);

  mvm_state_t state;
  logic [XBAR_SIZE-1:0][XBAR_SIZE-1:0][WT_BITS-1:0] wt;
  logic [XBAR_SIZE-1:0][IN_BITS-1:0]  in_lat;
  logic [N_BITS-1:0]                  ne;
  logic [N_BITS-1:0]                  k;
  logic                               sgn;
  logic [XBAR_SIZE-1:0][ACC_BITS-1:0] acc;
  logic [XBAR_SIZE-1:0][ACC_BITS-1:0] acc_nxt;
  logic [XBAR_SIZE-1:0][OUT_BITS-1:0] col_out;
  logic [XBAR_SIZE-1:0]               col_sat;
  logic [XBAR_SIZE-1:0]               slice_bits;
  logic [N_BITS-1:0]                  n_eff;
  logic                               is_last;
  logic                               last_neg;

  assign n_eff    = (n == '0 || n > N_BITS'(IN_BITS)) ? N_BITS'(IN_BITS) : n;
  assign is_last  = (k == ne - N_BITS'(1));
  // The top slice of a two's-complement input carries negative weight.
  assign last_neg = sgn && is_last;

  always_comb begin
    slice_bits = '0;
    for (int i = 0; i < XBAR_SIZE; i++) slice_bits[i] = in_lat[i][k[K_BITS-1:0]];
  end

  for (genvar j = 0; j < XBAR_SIZE; j++) begin : g_col
    logic [XBAR_SIZE-1:0][WT_BITS-1:0] col_wt;
    logic signed [P_BITS-1:0]          p;
    logic signed [ACC_BITS-1:0]        term;
    logic signed [ACC_BITS-1:0]        nxt;
    logic signed [63:0]                clipped;

    always_comb begin
      col_wt = '0;
      for (int i = 0; i < XBAR_SIZE; i++) col_wt[i] = wt[i][j];
    end

    mvm_bitslice_dot #(
      .XBAR_SIZE (XBAR_SIZE),
      .WT_BITS   (WT_BITS),
      .P_BITS    (P_BITS)
    ) u_dot (
      .in_bits (slice_bits),
      .col_wt  (col_wt),
      .p       (p)
    );

    assign term       = ACC_BITS'(p) <<< k;
    assign nxt        = last_neg ? $signed(acc[j]) - term : $signed(acc[j]) + term;
    assign clipped    = sat_clip(64'(nxt), OUT_BITS);
    assign acc_nxt[j] = nxt;
    assign col_out[j] = clipped[OUT_BITS-1:0];
    assign col_sat[j] = (clipped != 64'(nxt));
  end

  always_ff @(posedge clk) begin
    if (reset_wt) begin
      wt <= '0;
    end else if (prog_wt && state == IDLE) begin
      wt[wt_row_addr] <= wr_weight;
    end
  end

  // The final slice writes the clipped result directly so it is valid alongside mvm_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mvm_done    <= 1'b0;
      sat         <= 1'b0;
      xbar_output <= '0;
      acc         <= '0;
      k           <= '0;
      ne          <= '0;
      sgn         <= 1'b0;
      in_lat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          mvm_done <= 1'b0;
          if (mvm_start) begin
            in_lat      <= xbar_input;
            ne          <= n_eff;
            sgn         <= in_signed;
            acc         <= '0;
            sat         <= 1'b0;
            xbar_output <= '0;
            k           <= '0;
            busy        <= 1'b1;
            state       <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc <= acc_nxt;
          k   <= k + N_BITS'(1);
          if (is_last) begin
            xbar_output <= col_out;
            sat         <= |col_sat;
            mvm_done    <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          mvm_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_bitserial.sv
// tb/tb_mvm_bitserial.sv - randomized and directed bench against an arithmetic MVM model
module tb_mvm_bitserial;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_wt = 1'b1;
  logic mvm_start = 1'b0;
  logic [4:0] n = '0;
  logic in_signed = 1'b0;
  logic [15:0][15:0] xbar_input = '0;
  logic prog_wt = 1'b0;
  logic [3:0] wt_row_addr = '0;
  logic [15:0][15:0] wr_weight = '0;

  logic busy_a, done_a, sat_a;
  logic [15:0][31:0] out_a;
  logic busy_b, done_b, sat_b;
  logic [15:0][15:0] out_b;

  int n_checks = 0;
  int n_fail = 0;
  longint mw [16][16];
  longint exp_a [16];
  longint exp_b [16];
  bit exp_sat_a, exp_sat_b;
  int exp_ne;

  always #5 clk = ~clk;

  mvm_bitserial dut_a (
    .clk(clk), .reset(reset), .reset_wt(reset_wt), .mvm_start(mvm_start), .n(n),
    .in_signed(in_signed), .xbar_input(xbar_input), .prog_wt(prog_wt),
    .wt_row_addr(wt_row_addr), .wr_weight(wr_weight), .busy(busy_a),
    .mvm_done(done_a), .sat(sat_a), .xbar_output(out_a)
  );

  mvm_bitserial #(.OUT_BITS(16)) dut_b (
    .clk(clk), .reset(reset), .reset_wt(reset_wt), .mvm_start(mvm_start), .n(n),
    .in_signed(in_signed), .xbar_input(xbar_input), .prog_wt(prog_wt),
    .wt_row_addr(wt_row_addr), .wr_weight(wr_weight), .busy(busy_b),
    .mvm_done(done_b), .sat(sat_b), .xbar_output(out_b)
  );

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint clip(input longint v, input int bits);
    longint hi = (longint'(1) <<< (bits - 1)) - 1;
    longint lo = -hi - 1;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  task automatic compute_model();
    longint v, sum;
    exp_ne = (n == 0 || n > 16) ? 16 : int'(n);
    exp_sat_a = 1'b0;
    exp_sat_b = 1'b0;
    for (int j = 0; j < 16; j++) begin
      sum = 0;
      for (int i = 0; i < 16; i++) begin
        v = longint'(xbar_input[i]) & ((longint'(1) <<< exp_ne) - 1);
        if (in_signed && v[exp_ne-1]) v = v - (longint'(1) <<< exp_ne);
        sum += v * mw[i][j];
      end
      exp_a[j] = clip(sum, 32);
      exp_b[j] = clip(sum, 16);
      if (exp_a[j] != sum) exp_sat_a = 1'b1;
      if (exp_b[j] != sum) exp_sat_b = 1'b1;
    end
  endtask

  task automatic prog_row(input int r, input logic [15:0][15:0] d);
    wt_row_addr = 4'(r);
    wr_weight = d;
    prog_wt = 1'b1;
    tick();
    prog_wt = 1'b0;
    for (int j = 0; j < 16; j++) mw[r][j] = longint'($signed(d[j]));
  endtask

  task automatic prog_all(input logic [15:0] val);
    logic [15:0][15:0] d;
    for (int j = 0; j < 16; j++) d[j] = val;
    for (int r = 0; r < 16; r++) prog_row(r, d);
  endtask

  task automatic fill_inputs(input logic [15:0] val);
    for (int i = 0; i < 16; i++) xbar_input[i] = val;
  endtask

  task automatic wait_done(input string tag, input int cnt0);
    int cnt = cnt0;
    while (!done_a && cnt < 100) begin
      tick();
      cnt++;
    end
    check_val({tag, " latency"}, cnt, exp_ne + 1);
    check_val({tag, " done_b"}, longint'(done_b), 1);
    check_val({tag, " busy at done"}, longint'(busy_a), 0);
    for (int j = 0; j < 16; j++) begin
      check_val($sformatf("%s out32[%0d]", tag, j), longint'($signed(out_a[j])), exp_a[j]);
      check_val($sformatf("%s out16[%0d]", tag, j), longint'($signed(out_b[j])), exp_b[j]);
    end
    check_val({tag, " sat32"}, longint'(sat_a), longint'(exp_sat_a));
    check_val({tag, " sat16"}, longint'(sat_b), longint'(exp_sat_b));
    tick();
    check_val({tag, " done one cycle"}, longint'(done_a), 0);
  endtask

  // Any row write staged by the caller lands in the same cycle as the start.
  task automatic run_op(input string tag);
    compute_model();
    mvm_start = 1'b1;
    tick();
    mvm_start = 1'b0;
    prog_wt = 1'b0;
    check_val({tag, " busy"}, longint'(busy_a), 1);
    check_val({tag, " cleared out"}, longint'(|out_a), 0);
    wait_done(tag, 1);
  endtask

  initial begin
    logic [15:0][15:0] d;
    int seen;
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) mw[i][j] = 0;
    tick();
    tick();
    reset = 1'b0;
    reset_wt = 1'b0;
    check_val("rst busy", longint'(busy_a), 0);
    check_val("rst done", longint'(done_a), 0);
    check_val("rst sat", longint'(sat_a), 0);
    check_val("rst out32", longint'(|out_a), 0);
    check_val("rst out16", longint'(|out_b), 0);

    fill_inputs(16'h0001); n = 5'd16; in_signed = 1'b0;
    run_op("zero_wt");

    prog_all(16'h0001);
    fill_inputs(16'h0003); n = 5'd2;
    run_op("ones_n2");
    fill_inputs(16'hFF03);
    run_op("ones_hibits");

    prog_all(16'h0000);
    for (int j = 0; j < 16; j++) d[j] = 16'(j + 1);
    prog_row(0, d);
    fill_inputs(16'h0000); xbar_input[0] = 16'hFFFF; n = 5'd16; in_signed = 1'b1;
    run_op("row0_signed");
    in_signed = 1'b0;
    run_op("row0_unsigned");

    prog_all(16'h7FFF);
    fill_inputs(16'h7FFF); in_signed = 1'b1;
    run_op("sat_pos");
    fill_inputs(16'h8000);
    run_op("sat_neg");

    prog_all(16'h0001);
    fill_inputs(16'h0003); n = 5'd2; in_signed = 1'b0;
    mvm_start = 1'b1;
    tick();
    mvm_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("midrst busy", longint'(busy_a), 0);
    check_val("midrst done", longint'(done_a), 0);
    check_val("midrst out", longint'(|out_a), 0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      seen |= int'(done_a);
      tick();
    end
    check_val("midrst no done", seen, 0);
    run_op("after_rst");

    n = 5'd4;
    compute_model();
    mvm_start = 1'b1;
    tick();
    mvm_start = 1'b0;
    tick();
    for (int j = 0; j < 16; j++) d[j] = 16'd5;
    wt_row_addr = 4'd0; wr_weight = d; prog_wt = 1'b1; mvm_start = 1'b1;
    tick();
    prog_wt = 1'b0; mvm_start = 1'b0;
    wait_done("busy_ignore", 3);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      seen |= int'(done_a);
      tick();
    end
    check_val("busy_ignore no 2nd done", seen, 0);
    run_op("wt_unchanged");

    for (int r = 0; r < 10; r++) begin
      for (int q = 0; q < 2; q++) begin
        for (int j = 0; j < 16; j++) d[j] = 16'($urandom);
        prog_row(int'($urandom_range(0, 15)), d);
      end
      for (int i = 0; i < 16; i++) xbar_input[i] = 16'($urandom);
      n = 5'($urandom_range(0, 31));
      in_signed = 1'($urandom);
      if (r % 3 == 0) begin
        for (int j = 0; j < 16; j++) d[j] = 16'($urandom);
        wt_row_addr = 4'($urandom_range(0, 15));
        wr_weight = d;
        prog_wt = 1'b1;
        for (int j = 0; j < 16; j++) mw[wt_row_addr][j] = longint'($signed(d[j]));
      end
      run_op($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mvm_bitserial.md
Name: mvm_bitserial

Overview:
Parametrised successor to the fixed-size crossbar MVM unit. It computes out[j] = sum over i of in[i]*W[i][j] on an XBAR_SIZE x XBAR_SIZE weight crossbar. Inputs stream bit-serially, LSB first, with shift-and-add accumulation. New capabilities:
- runtime input precision n
- signed or unsigned input mode
- row-addressed weight programming
- output saturation

It sits in the core datapath between the input register file and the output buffer, in place of the fixed mvm block.

Parameters:
XBAR_SIZE, 16, crossbar rows and columns
IN_BITS, 16, maximum input width (bit-serial slices)
WT_BITS, 16, signed two's-complement weight width
OUT_BITS, 32, output width; saturating when smaller than ACC_BITS
N_BITS, $clog2(IN_BITS+1), width of the runtime precision field

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears FSM, accumulators and outputs; weights kept
reset_wt  input  1  synchronous, active-high; clears all weights to 0
mvm_start  input  1  start request, sampled in IDLE only
n  input  N_BITS  input precision for this operation; 0 or >IN_BITS means IN_BITS
in_signed  input  1  1 = inputs are n-bit two's complement
xbar_input  input  [XBAR_SIZE] x IN_BITS  input vector, latched at start
prog_wt  input  1  weight row write enable
wt_row_addr  input  $clog2(XBAR_SIZE)  row to write
wr_weight  input  [XBAR_SIZE] x WT_BITS  row data; element j is W[row][j]
busy  output  1  computation in progress
mvm_done  output  1  one-cycle completion pulse
sat  output  1  at least one output saturated in the last operation
xbar_output  output  [XBAR_SIZE] x OUT_BITS  signed result, held until the next start

Behaviour:
- Reset values: busy=0, mvm_done=0, sat=0, xbar_output all 0, FSM=IDLE. Accumulators are cleared by reset; weights are cleared only by reset_wt.
- ACC_BITS = IN_BITS + WT_BITS + $clog2(XBAR_SIZE) + 1. Accumulators are signed ACC_BITS wide.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE: when mvm_start=1 at cycle t:
  - latch xbar_input, effective n (ne) and in_signed
  - clear accumulators and sat
  - set k=0
  - go to COMPUTE; busy=1 from t+1.
- COMPUTE, cycle for slice k:
  - p_j = sum over i of bit_k(in[i]) * W[i][j], signed.
  - acc_j += p_j << k.
  - If in_signed and k == ne-1, acc_j -= p_j << k instead.
  - k increments; after slice ne-1, go to DONE.
  - Compute cycles are t+1 .. t+ne.
- DONE, cycle t+ne+1:
  - xbar_output[j] = sat_to_OUT_BITS(acc_j); sat is set if any column clipped.
  - mvm_done=1 and busy=0 in this cycle; return to IDLE.
  - Total latency from start to done is ne+1 cycles.
- Saturation: clip to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]. No clipping ever occurs when OUT_BITS >= ACC_BITS.
- Input bits at or above ne are ignored.
- xbar_output and sat hold their values until the next accepted start. In the cycle after that start they are cleared to 0.
- mvm_start while busy or in DONE: ignored, no queuing.
- prog_wt:
  - In IDLE, W[wt_row_addr] is written at the clock edge and is visible to a start in the following cycle.
  - While busy or in DONE, the write is ignored and weights are unchanged.
  - prog_wt and mvm_start in the same IDLE cycle: the write happens and the start is accepted; computation uses the new row.
- reset_wt takes priority over prog_wt. reset_wt while busy clears the weights immediately; remaining slices use zero weights.
- reset mid-operation: return to IDLE next cycle; busy=0, outputs 0, no mvm_done pulse.
- reset and mvm_start asserted together: reset wins.

Decomposition:
- Shared package mvm_pkg:
  - state enum mvm_state_t {IDLE, COMPUTE, DONE}
  - function acc_bits(in, wt, size)
  - function sat_clip(acc, out_bits)
- One sub-module, mvm_bitslice_dot: combinational, one column. Takes the XBAR_SIZE input bits and that column's weights, produces signed p_j. Instantiated XBAR_SIZE times with generate.

Test Plan:
1. reset_wt, reset; all inputs 16'h0001, n=16, unsigned, start -> all outputs 0, mvm_done exactly 17 cycles after start, sat=0.
2. Program all 16 rows to W=1; inputs all 3, n=2, unsigned, start -> every xbar_output = 48, done 3 cycles after start; bits above bit 1 set in inputs (input 16'hFF03) -> still 48.
3. W[0][j]=j+1, other rows 0; in[0]=16'hFFFF, others 0, in_signed=1, n=16 -> xbar_output[j] = -(j+1). Same stimulus with in_signed=0 -> 65535*(j+1).
4. OUT_BITS=16 instance; all W=16'h7FFF, all inputs 16'h7FFF, signed, n=16 -> every output 16'h7FFF, sat=1. All inputs 16'h8000 -> every output 16'h8000, sat=1.
5. Scenario 2 with reset pulsed on the 2nd compute cycle -> busy=0 next cycle, outputs 0, no mvm_done. Rerun without the reset -> 48 (weights retained).
6. During busy, pulse mvm_start and prog_wt with row 0 = all 5 -> no second done, result unchanged (48), W unchanged on a subsequent run.
